// File: rtl/dm_arbiter_pkg.sv
// Shared constants and lock FSM encodings for the data-memory arbiter.
// DM_ARB_LOCK_EN enables the ownership-lock FSM in dm_arbiter.
package dm_arbiter_pkg;

  localparam int DM_AW       = 12;
  localparam int DM_DW       = 256;
  localparam int DM_MAX_LOCK = 8;
  localparam int DM_CW       = $clog2(DM_MAX_LOCK);

  typedef enum logic [1:0] {
    DMARB_IDLE = 2'd0,
    DMARB_OWN0 = 2'd1,
    DMARB_OWN1 = 2'd2
  } dmarb_state_e;

endpackage

// File: rtl/dm_arbiter_if.sv
// Requester and memory-side signals of the data-memory arbiter.
// slave = arbiter side, master = requesters plus memory.
interface dm_arbiter_if;
  import dm_arbiter_pkg::*;

  logic             req0, req1;
  logic             we0, we1;
  logic [DM_AW-1:0] addr0, addr1;
  logic [DM_DW-1:0] wdata0, wdata1;
  logic             lock0, lock1;
  logic             gnt0, gnt1;
  logic             rvalid0, rvalid1;
  logic [DM_DW-1:0] rdata0, rdata1;
  logic             dm_wen;
  logic [DM_AW-1:0] dm_waddr, dm_raddr;
  logic [DM_DW-1:0] dm_wdata, dm_rdata;

  modport slave (
    input  req0, req1, we0, we1,
    input  addr0, addr1, wdata0, wdata1,
    input  lock0, lock1, dm_rdata,
    output gnt0, gnt1, rvalid0, rvalid1,
    output rdata0, rdata1,
    output dm_wen, dm_waddr, dm_raddr, dm_wdata
  );

  modport master (
    output req0, req1, we0, we1,
    output addr0, addr1, wdata0, wdata1,
    output lock0, lock1, dm_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1,
    input  rdata0, rdata1,
    input  dm_wen, dm_waddr, dm_raddr, dm_wdata
  );

endinterface

// File: rtl/dm_arbiter_rr_pick.sv
// Two-input round-robin picker: on a tie the port other than ptr wins.
module dm_rr_pick (
  input  logic [1:0] i_req,
  input  logic       i_ptr,
  output logic [1:0] o_gnt
);

  assign o_gnt = (&i_req) ? (i_ptr ? 2'b01 : 2'b10) : i_req;

endmodule

// File: rtl/dm_arbiter.sv
// Round-robin arbiter for the single-port line data memory.
// Define DM_ARB_LOCK_EN to enable multi-beat ownership locking.
module dm_arbiter
  import dm_arbiter_pkg::*;
(
  input logic         clk,
  input logic         rst,
  dm_arbiter_if.slave bus
);

  logic             r_rr_ptr;
  logic [1:0]       w_req;
  logic [1:0]       w_gnt;
  logic             w_sel1;
  logic             w_rd0, w_rd1;
  logic             r_rvalid0, r_rvalid1;
  logic [DM_DW-1:0] r_rdata0, r_rdata1;

`ifdef DM_ARB_LOCK_EN
  localparam logic [DM_CW-1:0] LAST = DM_CW'(DM_MAX_LOCK - 1);

  dmarb_state_e   r_state;
  logic [DM_CW-1:0] r_beat;

  always_comb begin
    w_req = {bus.req1, bus.req0};
    case (r_state)
      DMARB_OWN0: w_req[1] = 1'b0;
      DMARB_OWN1: w_req[0] = 1'b0;
      default:    ;
    endcase
    if (rst) w_req = 2'b00;
  end

  // rr_ptr already equals the owner on exit, since every
  // grant during ownership went to that port.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= DMARB_IDLE;
      r_beat  <= '0;
    end else begin
      case (r_state)
        DMARB_IDLE: begin
          if (w_gnt[0] && bus.lock0) begin
            r_state <= DMARB_OWN0;
            r_beat  <= DM_CW'(1);
          end else if (w_gnt[1] && bus.lock1) begin
            r_state <= DMARB_OWN1;
            r_beat  <= DM_CW'(1);
          end
        end
        DMARB_OWN0: begin
          if (!bus.lock0 || (w_gnt[0] && r_beat == LAST)) begin
            r_state <= DMARB_IDLE;
            r_beat  <= '0;
          end else if (w_gnt[0]) begin
            r_beat <= r_beat + DM_CW'(1);
          end
        end
        DMARB_OWN1: begin
          if (!bus.lock1 || (w_gnt[1] && r_beat == LAST)) begin
            r_state <= DMARB_IDLE;
            r_beat  <= '0;
          end else if (w_gnt[1]) begin
            r_beat <= r_beat + DM_CW'(1);
          end
        end
        default: begin
          r_state <= DMARB_IDLE;
          r_beat  <= '0;
        end
      endcase
    end
  end
`else
  logic w_unused_lock;

  assign w_unused_lock = bus.lock0 ^ bus.lock1;
  assign w_req = rst ? 2'b00 : {bus.req1, bus.req0};
`endif

  dm_rr_pick u_pick (
    .i_req (w_req),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_gnt)
  );

  assign w_sel1 = w_gnt[1];
  assign w_rd0  = w_gnt[0] & ~bus.we0;
  assign w_rd1  = w_gnt[1] & ~bus.we1;

  assign bus.gnt0     = w_gnt[0];
  assign bus.gnt1     = w_gnt[1];
  assign bus.dm_raddr = w_sel1 ? bus.addr1 : bus.addr0;
  assign bus.dm_waddr = w_sel1 ? bus.addr1 : bus.addr0;
  assign bus.dm_wdata = w_sel1 ? bus.wdata1 : bus.wdata0;
  assign bus.dm_wen   = (w_gnt[0] & bus.we0)
                      | (w_gnt[1] & bus.we1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr  <= 1'b1;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
    end else begin
      r_rvalid0 <= w_rd0;
      r_rvalid1 <= w_rd1;
      if (w_rd0) r_rdata0 <= bus.dm_rdata;
      if (w_rd1) r_rdata1 <= bus.dm_rdata;
      if (|w_gnt) r_rr_ptr <= w_gnt[1];
    end
  end

  assign bus.rvalid0 = r_rvalid0;
  assign bus.rvalid1 = r_rvalid1;
  assign bus.rdata0  = r_rdata0;
  assign bus.rdata1  = r_rdata1;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed scoreboard bench for dm_arbiter with a behavioural line memory.
// Build with DM_ARB_LOCK_EN to exercise the ownership-lock variant.
module tb_dm_arbiter;
  import dm_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dm_arbiter_if bus();

  dm_arbiter u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  localparam logic [DM_DW-1:0] P10  = {16{16'h1010}};
  localparam logic [DM_DW-1:0] P20  = {16{16'h2020}};
  localparam logic [DM_DW-1:0] P30  = {16{16'h3030}};
  localparam logic [DM_DW-1:0] PA5  = {16{16'hA5A5}};
  localparam logic [DM_DW-1:0] PNEW = {16{16'h5A3C}};

  logic [DM_DW-1:0] mem [0:(1<<DM_AW)-1];

  // memory is preloaded while reset is held
  always @(posedge clk) begin
    if (rst) begin
      mem[12'h005] <= '0;
      mem[12'h010] <= P10;
      mem[12'h020] <= P20;
      mem[12'h030] <= P30;
    end else if (bus.dm_wen) begin
      mem[bus.dm_waddr] <= bus.dm_wdata;
    end
  end
  assign bus.dm_rdata = mem[bus.dm_raddr];

  int n_chk  = 0;
  int n_fail = 0;
  logic [DM_DW-1:0] model [int];
  logic [DM_DW-1:0] q0 [$];
  logic [DM_DW-1:0] q1 [$];

  task automatic chk(input string tag, input logic [DM_DW-1:0] obs,
                     input logic [DM_DW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set0(input logic r, input logic w,
                      input logic [DM_AW-1:0] a,
                      input logic [DM_DW-1:0] d, input logic l);
    bus.req0 = r; bus.we0 = w; bus.addr0 = a;
    bus.wdata0 = d; bus.lock0 = l;
  endtask

  task automatic set1(input logic r, input logic w,
                      input logic [DM_AW-1:0] a,
                      input logic [DM_DW-1:0] d, input logic l);
    bus.req1 = r; bus.we1 = w; bus.addr1 = a;
    bus.wdata1 = d; bus.lock1 = l;
  endtask

  // called just after inputs are driven at a negedge
  task automatic cyc(input string tag, input logic eg0, input logic eg1);
    logic e_rv0, e_rv1;
    #1;
    chk({tag, ":gnt0"}, DM_DW'(bus.gnt0), DM_DW'(eg0));
    chk({tag, ":gnt1"}, DM_DW'(bus.gnt1), DM_DW'(eg1));
    chk({tag, ":wen"}, DM_DW'(bus.dm_wen),
        DM_DW'((eg0 & bus.we0) | (eg1 & bus.we1)));
    e_rv0 = eg0 & ~bus.we0;
    e_rv1 = eg1 & ~bus.we1;
    if (e_rv0) q0.push_back(model[int'(bus.addr0)]);
    if (e_rv1) q1.push_back(model[int'(bus.addr1)]);
    if (eg0 & bus.we0) model[int'(bus.addr0)] = bus.wdata0;
    if (eg1 & bus.we1) model[int'(bus.addr1)] = bus.wdata1;
    @(posedge clk);
    #1;
    chk({tag, ":rvalid0"}, DM_DW'(bus.rvalid0), DM_DW'(e_rv0));
    chk({tag, ":rvalid1"}, DM_DW'(bus.rvalid1), DM_DW'(e_rv1));
    if (bus.rvalid0 && q0.size() > 0)
      chk({tag, ":rdata0"}, bus.rdata0, q0.pop_front());
    if (bus.rvalid1 && q1.size() > 0)
      chk({tag, ":rdata1"}, bus.rdata1, q1.pop_front());
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic e1;
    model[12'h010] = P10;
    model[12'h020] = P20;
    model[12'h030] = P30;

    // 1: reset with both requesting, then first tie
    rst = 1'b1;
    set0(1, 0, 12'h010, '0, 0);
    set1(1, 0, 12'h020, '0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cyc("t1_rst", 0, 0);
      chk("t1_rdata0", bus.rdata0, '0);
      chk("t1_rdata1", bus.rdata1, '0);
    end
    @(negedge clk); rst = 1'b0;
    cyc("t1_tie", 1, 0);
    @(negedge clk); set0(0, 0, 12'h010, '0, 0);
    cyc("t1_p1", 0, 1);

    // 2: write then read the same line
    @(negedge clk); set0(1, 1, 12'h005, PA5, 0); set1(0, 0, 12'h020, '0, 0);
    cyc("t2_wr", 1, 0);
    @(negedge clk); set0(1, 0, 12'h005, '0, 0);
    cyc("t2_rd", 1, 0);
    chk("t2_line", bus.rdata0, PA5);

    // 3: sustained contention alternates, starting at port 0
    @(negedge clk); set0(0, 0, 12'h010, '0, 0); set1(1, 0, 12'h020, '0, 0);
    cyc("t3_pre", 0, 1);
    @(negedge clk); set0(1, 0, 12'h010, '0, 0);
    for (int i = 0; i < 6; i++) begin
      cyc("t3_alt", (i % 2) == 0, (i % 2) == 1);
      @(negedge clk);
    end

    // 4: same-cycle write/read of one line
    set0(1, 1, 12'h030, PNEW, 0); set1(1, 0, 12'h030, '0, 0);
    cyc("t4_wr", 1, 0);
    chk("t4_hold1", bus.rdata1, P20);
    @(negedge clk); set0(0, 0, 12'h030, '0, 0);
    cyc("t4_rd", 0, 1);
    chk("t4_new", bus.rdata1, PNEW);

    // 5: port 1 locks while port 0 contends
    @(negedge clk); set0(1, 0, 12'h010, '0, 0); set1(0, 0, 12'h020, '0, 0);
    cyc("t5_pre", 1, 0);
    @(negedge clk); set1(1, 0, 12'h020, '0, 1);
    for (int i = 0; i < 12; i++) begin
`ifdef DM_ARB_LOCK_EN
      e1 = (i != DM_MAX_LOCK);
`else
      e1 = (i % 2) == 0;
`endif
      cyc("t5_lock", ~e1, e1);
      @(negedge clk);
    end
    set0(0, 0, 12'h010, '0, 0); set1(0, 0, 12'h020, '0, 0);
    cyc("t5_idle", 0, 0);

    // 6: reset lands on a granted read
    @(negedge clk); set0(1, 0, 12'h010, '0, 0);
    #1;
    chk("t6_gnt0", DM_DW'(bus.gnt0), DM_DW'(1'b1));
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t6_rv0", DM_DW'(bus.rvalid0), '0);
    chk("t6_rv1", DM_DW'(bus.rvalid1), '0);
    chk("t6_g0", DM_DW'(bus.gnt0), '0);
    set1(1, 0, 12'h020, '0, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      cyc("t6_rst", 0, 0);
    end
    @(negedge clk); rst = 1'b0;
    cyc("t6_rel", 1, 0);
    @(negedge clk); set0(0, 0, 12'h010, '0, 0); set1(0, 0, 12'h020, '0, 0);
    cyc("t6_end", 0, 0);

    chk("q0_empty", DM_DW'(q0.size()), '0);
    chk("q1_empty", DM_DW'(q1.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
